vcb_mod_cled: RTL and testbench
===============================

# vcb_mod_cled

Parametrised binary counter with a runtime-programmable modulus, up/down direction, synchronous load, and three end-of-range modes: wrap, saturate, one-shot. It generalises the fixed-range loadable up/down counter with terminal count and cascade enable. It sits in the counters project as the common timebase, divider and event-count block. Its `ceo` output chains instances into wider or mixed-radix counters.

## Interface

Parameters
- `WIDTH`, 4 — counter, load-data and modulus width in bits.

Ports
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `clr`  in  1  — synchronous reset, active-high; highest priority.
- `ce`  in  1  — count enable.
- `up`  in  1  — direction: 1 counts up, 0 counts down.
- `l`  in  1  — synchronous load of `di`.
- `di`  in  WIDTH  — load value.
- `mod`  in  WIDTH  — maximum count value (`max`); the count range is 0..`mod`.
- `mode`  in  2  — 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- `q`  out  WIDTH  — count value (registered).
- `tc`  out  1  — terminal count (combinational).
- `ceo`  out  1  — cascade enable out (combinational).
- `wrp`  out  1  — one-cycle registered pulse after a wrap.
- `done`  out  1  — one-shot finished (registered, sticky).

## Operation

- Terminal value: `max` when `up`=1, 0 when `up`=0.
- `tc` = (`q` == terminal value).
- Update priority per edge, evaluated in this order:
  1. `clr`: `q`←0, `done`←0, `wrp`←0.
  2. `l`: `q`←min(`di`, `mod`), `done`←0, `wrp`←0. Load always works, even when `done`=1 or `ce`=0.
  3. `ce`=1 and not (`mode`=one-shot and `done`=1): step as below.
  4. Otherwise: hold `q`; `wrp`←0.
- Out-of-range step (`q` > `mod`, e.g. after `mod` was lowered): the next step sets `q`←0 in wrap mode and `q`←`max` in saturate or one-shot mode, in either direction. No `wrp` pulse. `tc` stays low while out of range unless `up`=0 and `q`=0.
- In-range step when `tc`=0: `q`←`q`+1 if `up`=1, `q`←`q`−1 if `up`=0. Arithmetic is modulo 2^WIDTH; no intermediate exceeds WIDTH bits.
- In-range step when `tc`=1:
  - wrap: `q`←0 (up) or `max` (down); `wrp`←1 for exactly one cycle.
  - saturate: `q` holds. Reversing `up` resumes counting.
  - one-shot: `q` holds; `done`←1. While `done`=1, `ce` and `up` are ignored; only `l` or `clr` restarts.
- `mod`=0: range is the single value 0. `tc`=1 continuously. In wrap mode every step pulses `wrp`.
- `ceo` = `ce` & `tc` & wrap-mode (00 or 11) & !`l` & !`clr`. It is high exactly on the cycles where the next edge wraps, so the next cascaded stage steps once per wrap.

## Timing

- Reset values after a `clr` edge: `q`=0, `wrp`=0, `done`=0. `tc` then equals (`up`=0 or `mod`=0). `ceo` is 0 while `clr` is high.
- `q`, `wrp` and `done` have 1-cycle latency from the qualifying edge.
- `tc` and `ceo` are combinational from `q` and the current inputs. There is no registered delay between them.
- `wrp` rises on the same edge that `q` wraps and falls on the next edge.
- `done` rises on the first `ce` edge with `tc`=1 in one-shot mode, not on the edge that reaches the terminal value.
- A `mode` or `mod` change takes effect on the next edge. `q` is never modified by the change itself.
- Simultaneous `clr` and `l`: `clr` wins. Simultaneous `l` and `ce`: load wins, no step.

## Test plan

- Reset/load/clamp (WIDTH=4, `mod`=9): `clr`=1 for one edge → `q`=0, `done`=0. Then `l`=1, `di`=6 → `q`=6. Then `di`=12 → `q`=9. Then `clr`=1 and `l`=1 together → `q`=0.
- Wrap up (`mod`=9, `ce`=1, `up`=1, from 0) → sequence 0..9,0 with period 10. `tc`=`ceo`=1 only while `q`=9. `wrp`=1 only in the cycle after `q` returns to 0.
- Wrap down (`up`=0, load 2) → 2,1,0,9,8. `tc`=1 at `q`=0; `wrp` pulse the cycle after `q`=9. With `mod`=0: `q` stays 0 and `wrp`=1 every cycle.
- Saturate (`mode`=01, `mod`=15, up from 13) → 14,15,15,15 with `ceo`=0 throughout. Set `up`=0 → 14,13.
- One-shot (`mode`=10, `mod`=9, load 6, up) → 7,8,9. `done`=1 one edge later. Toggling `up` leaves `q`=9. Load 3 → `q`=3, `done`=0, counting resumes.
- Out-of-range (wrap, `q`=8, change `mod` to 5, `up`=1) → next `q`=0, no `wrp`. Same in saturate mode → `q`=5.

Source files
------------

// File: rtl/vcb_mod_cled.sv
// vcb_mod_cled: programmable-modulus up/down counter with wrap, saturate and one-shot end modes
module vcb_mod_cled #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             up,
  input  logic             l,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] mod,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ceo,
  output logic             wrp,
  output logic             done
);
  logic             wrap_mode, one_mode, oor, step, hit;
  logic [WIDTH-1:0] q_step;
  always_comb begin
    wrap_mode = mode == 2'b00 || mode == 2'b11;
    one_mode  = mode == 2'b10;
    oor       = q > mod;
    tc        = q == (up ? mod : '0);
    ceo       = ce && tc && wrap_mode && !l && !clr;
    step      = ce && !(one_mode && done);
    hit       = !oor && tc;
    // out-of-range recovery takes precedence over normal stepping and never pulses wrp
    q_step    = oor ? (wrap_mode ? '0 : mod) :
                !tc ? (up ? q + 1'b1 : q - 1'b1) :
                wrap_mode ? (up ? '0 : mod) : q;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= '0;
      done <= 1'b0;
      wrp  <= 1'b0;
    end else if (l) begin
      q    <= di > mod ? mod : di;
      done <= 1'b0;
      wrp  <= 1'b0;
    end else if (step) begin
      q    <= q_step;
      wrp  <= hit && wrap_mode;
      done <= done || (hit && one_mode);
    end else
      wrp  <= 1'b0;
  end
endmodule

// File: tb/tb_vcb_mod_cled.sv
// tb_vcb_mod_cled: directed-vector bench for vcb_mod_cled with hand-computed expectations
module tb_vcb_mod_cled;
  logic       clk = 0, clr, ce, up, l, wrp, done, tc, ceo;
  logic [3:0] di, mod, q;
  logic [1:0] mode;
  int errors = 0, checks = 0;
  vcb_mod_cled #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .ce(ce), .up(up), .l(l), .di(di), .mod(mod),
    .mode(mode), .q(q), .tc(tc), .ceo(ceo), .wrp(wrp), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [3:0] v);
    ce = 0; l = 1; di = v;
    tick;
    l = 0;
  endtask
  initial begin
    clr = 1; ce = 0; up = 1; l = 0; di = 0; mod = 9; mode = 0;
    tick;
    chk("rst_q", q, 0); chk("rst_done", done, 0); chk("rst_wrp", wrp, 0); chk("rst_tc", tc, 0);
    ce = 1; up = 0; #1;
    chk("clr_tc", tc, 1); chk("clr_ceo", ceo, 0);
    clr = 0; #1;
    chk("ceo_down0", ceo, 1);
    ce = 0; up = 1;
    load(6);  chk("load6", q, 6);
    load(12); chk("clamp", q, 9);
    clr = 1; l = 1; di = 5; tick; clr = 0; l = 0;
    chk("clr_over_l", q, 0);
    l = 1; di = 3; ce = 1; tick; l = 0;
    chk("l_over_ce", q, 3);
    load(0); ce = 1; up = 1;
    for (int i = 1; i <= 11; i++) begin
      tick;
      chk("wrap_up_q", q, i % 10);
      chk("wrap_up_tc", tc, (i % 10) == 9);
      chk("wrap_up_ceo", ceo, (i % 10) == 9);
      chk("wrap_up_wrp", wrp, i == 10);
    end
    up = 0; load(2); ce = 1;
    begin
      logic [3:0] exp_q [4] = '{1, 0, 9, 8};
      for (int i = 0; i < 4; i++) begin
        tick;
        chk("wrap_dn_q", q, exp_q[i]);
        chk("wrap_dn_tc", tc, exp_q[i] == 0);
        chk("wrap_dn_wrp", wrp, exp_q[i] == 9);
      end
    end
    mod = 0; tick;
    chk("mod0_oor_q", q, 0); chk("mod0_oor_wrp", wrp, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mod0_q", q, 0); chk("mod0_wrp", wrp, 1); chk("mod0_tc", tc, 1);
    end
    mode = 1; mod = 15; up = 1; load(13); ce = 1;
    begin
      logic [3:0] exp_q [4] = '{14, 15, 15, 15};
      for (int i = 0; i < 4; i++) begin
        tick;
        chk("sat_q", q, exp_q[i]); chk("sat_ceo", ceo, 0); chk("sat_wrp", wrp, 0);
      end
    end
    up = 0; tick; chk("sat_rev1", q, 14);
    tick; chk("sat_rev2", q, 13);
    mode = 2; mod = 9; up = 1; load(6); ce = 1;
    for (int i = 7; i <= 9; i++) begin
      tick;
      chk("os_q", q, i); chk("os_done_early", done, 0);
    end
    tick; chk("os_hold", q, 9); chk("os_done", done, 1);
    up = 0; tick; chk("os_ign_up", q, 9); chk("os_done_sticky", done, 1);
    up = 1; tick; chk("os_ign_up2", q, 9);
    l = 1; di = 3; tick; l = 0;
    chk("os_reload_q", q, 3); chk("os_reload_done", done, 0);
    tick; chk("os_resume", q, 4);
    mode = 0; mod = 9; up = 1; load(8);
    mod = 5; #1; chk("oor_tc", tc, 0);
    up = 0; #1; chk("oor_tc_dn", tc, 0);
    up = 1; ce = 1; tick;
    chk("oor_wrap_q", q, 0); chk("oor_wrap_wrp", wrp, 0);
    mode = 1; mod = 9; load(8);
    mod = 5; ce = 1; tick;
    chk("oor_sat_q", q, 5); chk("oor_sat_wrp", wrp, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
